mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (ic) and data cache (dc).
- Grants one requester at a time and forwards its request, write-data and address channels to memory.
- For reads, holds the grant until all BEATS response beats have been routed back to the owner.
- Sits between the two cache instances and the memory model/DRAM interface.
- At most one memory transaction is outstanding at any time.

Parameters:
- ADDR_BITS, 28, memory line address width (`CPU_ADDR_BITS minus byte and word-in-line bits).
- DATA_BITS, `MEM_DATA_BITS (128), memory data width.
- BEATS, 4, response beats returned per read request.

Ports (notation {ic,dc}_x expands to one port per requester):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- {ic,dc}_req_valid  in  1  requester presents a request.
- {ic,dc}_req_ready  out  1  request accepted this cycle.
- {ic,dc}_req_addr  in  ADDR_BITS  line address.
- {ic,dc}_req_rw  in  1  0 = read, 1 = write.
- {ic,dc}_req_data_valid  in  1  write data valid.
- {ic,dc}_req_data_ready  out  1  write data accepted.
- {ic,dc}_req_data_bits  in  DATA_BITS  write data.
- {ic,dc}_req_data_mask  in  DATA_BITS/8  byte mask.
- {ic,dc}_resp_valid  out  1  response beat for this requester.
- {ic,dc}_resp_data  out  DATA_BITS  response data (both outputs carry mem_resp_data).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_BITS  forwarded address.
- mem_req_rw  out  1  forwarded rw.
- mem_req_data_valid  out  1  forwarded write-data valid.
- mem_req_data_ready  in  1  memory accepts write data.
- mem_req_data_bits  out  DATA_BITS  forwarded write data.
- mem_req_data_mask  out  DATA_BITS/8  forwarded mask.
- mem_resp_valid  in  1  read beat valid.
- mem_resp_data  in  DATA_BITS  read beat.

Behaviour:
- Registered state: state {IDLE, REQ, RESP}; owner (1 bit, 0 = ic, 1 = dc); addr_done; data_done; beat counter (ceilLog2(BEATS) bits).
- Reset: state = IDLE, counters and flags cleared. Every valid/ready output is 0. Address, data and mask outputs are 0 whenever not in REQ.
- IDLE:
  - If any req_valid is high, latch the winner into owner and go to REQ. Arbitration is fixed priority, dc over ic.
  - No ready is asserted in IDLE.
  - Latency: req_valid sampled at cycle N gives mem_req_valid at N+1.
- REQ, address channel:
  - mem_req_{valid,addr,rw} = owner's inputs, gated by !addr_done.
  - owner_req_ready = mem_req_ready & !addr_done. Non-owner ready is always 0.
- REQ, write (owner rw = 1), data channel:
  - mem_req_data_{valid,bits,mask} = owner's inputs, gated by !data_done.
  - owner_req_data_ready = mem_req_data_ready & !data_done.
  - Address and data handshakes may complete in either order or in the same cycle; each completes exactly once.
  - When both are done (including the same cycle), go to IDLE and clear the flags.
- REQ, read: mem_req_data_valid = 0. On address handshake, go to RESP with count = 0.
- A requester must hold valid and payload stable until accepted. If owner valid drops, the arbiter stays in REQ.
- RESP:
  - owner_resp_valid = mem_resp_valid; non-owner resp_valid = 0.
  - Count increments on each valid beat; the beat with count == BEATS-1 returns the block to IDLE.
  - Gaps between beats are allowed.
- mem_resp_valid outside RESP is dropped: no resp_valid is asserted.
- Reset asserted mid-transaction aborts the transaction; the next cycle is in IDLE.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- When defined:
  - Round-robin arbitration; a last_owner register is updated on every grant.
  - On conflict, the requester that was not last granted wins.
  - last_owner resets to ic, so dc wins the first conflict.
- When undefined: fixed priority, dc over ic, and no last_owner register.

Test Plan:
- ic read alone, addr 0x0000010, mem_req_ready = 1:
  - mem_req_valid one cycle after ic_req_valid, with addr 0x10 and rw 0.
  - Beats 0xA, 0xB, 0xC, 0xD produce four ic_resp_valid pulses with matching data; dc_resp_valid stays 0.
  - Back in IDLE after the fourth beat.
- ic read and dc write asserted in the same cycle, mem_req_data_ready held low 3 cycles:
  - dc is granted first; ic_req_ready stays 0 until the dc write completes.
  - ic is then granted in the following IDLE → REQ.
- dc write with mem_req_data_ready = 1 and mem_req_ready = 0 for 2 cycles:
  - Exactly one data handshake occurs.
  - mem_req_data_valid drops after it; IDLE follows the address handshake.
- Read with mem_resp_valid pattern 1,0,0,1,1,0,1:
  - Exactly 4 owner resp pulses; IDLE entered after the 7th cycle.
  - A stray beat afterwards asserts no resp_valid.
- Reset after 2 of 4 beats:
  - All outputs go to 0; the remaining beats are ignored.
  - A new ic read proceeds normally.
- MEM_ARB_RR_EN, both requesters continuously issuing reads: grants alternate dc, ic, dc, ic.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the instruction cache (ic) and
// the data cache (dc). One requester owns the port at a time, and at most one
// memory transaction is outstanding.
//
//   IDLE : pick a winner among the valid requesters and latch it as owner.
//   REQ  : forward the owner's address channel (and, for writes, its data
//          channel) to memory. The two write handshakes may finish in either
//          order or together, and each is taken exactly once.
//   RESP : reads only; route BEATS response beats back to the owner.
//
// Arbitration:
//   default        fixed priority, dc over ic.
//   MEM_ARB_RR_EN  round robin. On a conflict the requester that was not
//                  granted last wins. last_owner resets to ic, so dc wins the
//                  first conflict.
//
// Ports ({ic,dc}_x is one port per requester):
//   clk, reset                    clock, synchronous active-high reset
//   {ic,dc}_req_valid/ready       request handshake
//   {ic,dc}_req_addr/rw           line address, 0 = read / 1 = write
//   {ic,dc}_req_data_valid/ready  write-data handshake
//   {ic,dc}_req_data_bits/mask    write data and byte mask
//   {ic,dc}_resp_valid/data       response beat routed to the owner
//   mem_req_*                     forwarded request to memory
//   mem_resp_valid/data           read beats from memory
//
// Outputs are combinational functions of the registered state and the
// current handshake inputs. Address, data and mask outputs are 0 whenever
// the block is not in REQ.
// -----------------------------------------------------------------------------

`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif

module mem_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = `MEM_DATA_BITS,
  parameter int BEATS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  // instruction cache
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,

  // data cache
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,

  // memory port
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  // owner encoding: 0 = ic, 1 = dc
  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic                owner_q,     owner_d;
  logic                addr_done_q, addr_done_d;
  logic                data_done_q, data_done_d;
  logic [CNT_BITS-1:0] beat_cnt_q,  beat_cnt_d;
`ifdef MEM_ARB_RR_EN
  logic                last_owner_q, last_owner_d;
`endif

  // ---------------------------------------------------------------------------
  // Owner-side view of the request channels
  // ---------------------------------------------------------------------------
  logic                 own_valid;
  logic [ADDR_BITS-1:0] own_addr;
  logic                 own_rw;
  logic                 own_data_valid;
  logic [DATA_BITS-1:0] own_data_bits;
  logic [MASK_BITS-1:0] own_data_mask;

  assign own_valid      = (owner_q == OWNER_DC) ? dc_req_valid      : ic_req_valid;
  assign own_addr       = (owner_q == OWNER_DC) ? dc_req_addr       : ic_req_addr;
  assign own_rw         = (owner_q == OWNER_DC) ? dc_req_rw         : ic_req_rw;
  assign own_data_valid = (owner_q == OWNER_DC) ? dc_req_data_valid : ic_req_data_valid;
  assign own_data_bits  = (owner_q == OWNER_DC) ? dc_req_data_bits  : ic_req_data_bits;
  assign own_data_mask  = (owner_q == OWNER_DC) ? dc_req_data_mask  : ic_req_data_mask;

  // Each channel is live only until its handshake has been taken, so a
  // channel that finished early goes quiet while the other one catches up.
  logic addr_live;
  logic data_live;
  logic resp_live;

  assign addr_live = (state_q == S_REQ) && !addr_done_q;
  assign data_live = (state_q == S_REQ) && own_rw && !data_done_q;
  assign resp_live = (state_q == S_RESP) && mem_resp_valid;

  // ---------------------------------------------------------------------------
  // Memory-side outputs
  // ---------------------------------------------------------------------------
  assign mem_req_valid      = addr_live && own_valid;
  assign mem_req_addr       = addr_live ? own_addr : '0;
  assign mem_req_rw         = addr_live && own_rw;
  assign mem_req_data_valid = data_live && own_data_valid;
  assign mem_req_data_bits  = data_live ? own_data_bits : '0;
  assign mem_req_data_mask  = data_live ? own_data_mask : '0;

  // ---------------------------------------------------------------------------
  // Requester-side outputs; the non-owner never sees ready or a response.
  // ---------------------------------------------------------------------------
  logic own_req_ready;
  logic own_data_ready;

  assign own_req_ready  = addr_live && mem_req_ready;
  assign own_data_ready = data_live && mem_req_data_ready;

  assign ic_req_ready      = own_req_ready  && (owner_q == OWNER_IC);
  assign dc_req_ready      = own_req_ready  && (owner_q == OWNER_DC);
  assign ic_req_data_ready = own_data_ready && (owner_q == OWNER_IC);
  assign dc_req_data_ready = own_data_ready && (owner_q == OWNER_DC);

  assign ic_resp_valid = resp_live && (owner_q == OWNER_IC);
  assign dc_resp_valid = resp_live && (owner_q == OWNER_DC);
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  // ---------------------------------------------------------------------------
  // Arbitration: grant_dc is only consumed when at least one request is valid,
  // so a lone requester always resolves to itself.
  // ---------------------------------------------------------------------------
  logic grant_dc;

`ifdef MEM_ARB_RR_EN
  assign grant_dc = (ic_req_valid && dc_req_valid) ? (last_owner_q == OWNER_IC)
                                                   : dc_req_valid;
`else
  assign grant_dc = dc_req_valid;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic addr_hs;
  logic data_hs;
  logic addr_done_n;
  logic data_done_n;

  assign addr_hs     = mem_req_valid && mem_req_ready;
  assign data_hs     = mem_req_data_valid && mem_req_data_ready;
  assign addr_done_n = addr_done_q || addr_hs;
  assign data_done_n = data_done_q || data_hs;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    addr_done_d = addr_done_q;
    data_done_d = data_done_q;
    beat_cnt_d  = beat_cnt_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          owner_d     = grant_dc ? OWNER_DC : OWNER_IC;
          state_d     = S_REQ;
          addr_done_d = 1'b0;
          data_done_d = 1'b0;
          beat_cnt_d  = '0;
`ifdef MEM_ARB_RR_EN
          last_owner_d = grant_dc ? OWNER_DC : OWNER_IC;
`endif
        end
      end

      S_REQ: begin
        if (own_rw) begin
          // Write: leave once both handshakes have been taken, including the
          // case where they land in the same cycle.
          if (addr_done_n && data_done_n) begin
            state_d     = S_IDLE;
            addr_done_d = 1'b0;
            data_done_d = 1'b0;
          end else begin
            addr_done_d = addr_done_n;
            data_done_d = data_done_n;
          end
        end else if (addr_hs) begin
          state_d    = S_RESP;
          beat_cnt_d = '0;
        end
      end

      S_RESP: begin
        // Gaps between beats simply hold the count.
        if (mem_resp_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge value of every other register regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWNER_IC;
      addr_done_q <= 1'b0;
      data_done_q <= 1'b0;
      beat_cnt_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWNER_IC;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_done_q <= addr_done_d;
      data_done_q <= data_done_d;
      beat_cnt_q  <= beat_cnt_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule
